// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: forwards EX_MEM results to MEM_WB and runs loads/stores with a
// BUSY/stall handshake and timeout. Define MEM_STALL_CNT_EN to add the stall_cnt output.
module mem_access_stage #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_memread,
    input  logic        ex_memwrite,
    input  logic [15:0] ex_addr,
    input  logic [15:0] ex_wdata,
    input  logic [15:0] ex_aluval,
    input  logic [3:0]  ex_dstreg,
    input  logic        ex_regwrite,
    input  logic        ex_memtoreg,
    input  logic        ex_halt,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic [15:0] MEM_ALUval,
    output logic [15:0] MEM_ReadData,
    output logic [3:0]  MEM_DstReg,
    output logic        MEM_RegWrite,
    output logic        MEM_MemtoReg,
    output logic        MEM_halt,
    output logic        stall,
    output logic        mem_err
`ifdef MEM_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StHalted
    } state_e;

    state_e      state_q, state_d;

    // Instruction held while the memory access is in flight.
    logic [15:0] lat_addr_q, lat_addr_d;
    logic [15:0] lat_wdata_q, lat_wdata_d;
    logic [15:0] lat_alu_q, lat_alu_d;
    logic [3:0]  lat_dst_q, lat_dst_d;
    logic        lat_rw_q, lat_rw_d;
    logic        lat_m2r_q, lat_m2r_d;
    logic        lat_halt_q, lat_halt_d;
    logic        lat_wr_q, lat_wr_d;

    logic [3:0]  wait_q, wait_d;
    logic [4:0]  wait_inc;
    logic        timeout;
    logic        err_q, err_d;

    logic [15:0] alu_q, alu_d;
    logic [15:0] rdata_q, rdata_d;
    logic [3:0]  dst_q, dst_d;
    logic        rw_q, rw_d;
    logic        m2r_q, m2r_d;
    logic        halt_q, halt_d;

    logic        busy;

    assign busy     = (state_q == StBusy);
    assign wait_inc = {1'b0, wait_q} + 5'd1;
    assign timeout  = (32'(wait_inc) >= MAX_WAIT);

    always_comb begin
        state_d     = state_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        lat_alu_d   = lat_alu_q;
        lat_dst_d   = lat_dst_q;
        lat_rw_d    = lat_rw_q;
        lat_m2r_d   = lat_m2r_q;
        lat_halt_d  = lat_halt_q;
        lat_wr_d    = lat_wr_q;
        wait_d      = wait_q;
        err_d       = err_q;
        // Outputs default to a bubble; only a retiring instruction overrides them.
        alu_d       = 16'h0000;
        rdata_d     = 16'h0000;
        dst_d       = 4'h0;
        rw_d        = 1'b0;
        m2r_d       = 1'b0;
        halt_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (ex_valid) begin
                    if (ex_memread || ex_memwrite) begin
                        lat_addr_d  = ex_addr;
                        lat_wdata_d = ex_wdata;
                        lat_alu_d   = ex_aluval;
                        lat_dst_d   = ex_dstreg;
                        lat_rw_d    = ex_regwrite;
                        lat_m2r_d   = ex_memtoreg;
                        lat_halt_d  = ex_halt;
                        // A simultaneous read and write is treated as a read.
                        lat_wr_d    = ex_memwrite & ~ex_memread;
                        wait_d      = 4'h0;
                        state_d     = StBusy;
                    end else begin
                        alu_d  = ex_aluval;
                        dst_d  = ex_dstreg;
                        rw_d   = ex_regwrite;
                        m2r_d  = ex_memtoreg;
                        halt_d = ex_halt;
                        if (ex_halt) begin
                            state_d = StHalted;
                        end
                    end
                end
            end
            StBusy: begin
                if (mem_ready) begin
                    alu_d   = lat_alu_q;
                    rdata_d = lat_wr_q ? 16'h0000 : mem_rdata;
                    dst_d   = lat_dst_q;
                    rw_d    = lat_rw_q;
                    m2r_d   = lat_m2r_q;
                    halt_d  = lat_halt_q;
                    state_d = lat_halt_q ? StHalted : StIdle;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    wait_d = wait_inc[3:0];
                end
            end
            StHalted: begin
                state_d = StHalted;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            lat_addr_q  <= 16'h0000;
            lat_wdata_q <= 16'h0000;
            lat_alu_q   <= 16'h0000;
            lat_dst_q   <= 4'h0;
            lat_rw_q    <= 1'b0;
            lat_m2r_q   <= 1'b0;
            lat_halt_q  <= 1'b0;
            lat_wr_q    <= 1'b0;
            wait_q      <= 4'h0;
            err_q       <= 1'b0;
            alu_q       <= 16'h0000;
            rdata_q     <= 16'h0000;
            dst_q       <= 4'h0;
            rw_q        <= 1'b0;
            m2r_q       <= 1'b0;
            halt_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
            lat_alu_q   <= lat_alu_d;
            lat_dst_q   <= lat_dst_d;
            lat_rw_q    <= lat_rw_d;
            lat_m2r_q   <= lat_m2r_d;
            lat_halt_q  <= lat_halt_d;
            lat_wr_q    <= lat_wr_d;
            wait_q      <= wait_d;
            err_q       <= err_d;
            alu_q       <= alu_d;
            rdata_q     <= rdata_d;
            dst_q       <= dst_d;
            rw_q        <= rw_d;
            m2r_q       <= m2r_d;
            halt_q      <= halt_d;
        end
    end

    // Memory request is a pure function of state so it drops the cycle after reset or completion.
    assign mem_en    = busy;
    assign mem_wr    = busy & lat_wr_q;
    assign mem_addr  = busy ? lat_addr_q : 16'h0000;
    assign mem_wdata = busy ? lat_wdata_q : 16'h0000;
    assign stall     = busy;
    assign mem_err   = err_q;

    assign MEM_ALUval   = alu_q;
    assign MEM_ReadData = rdata_q;
    assign MEM_DstReg   = dst_q;
    assign MEM_RegWrite = rw_q;
    assign MEM_MemtoReg = m2r_q;
    assign MEM_halt     = halt_q;

`ifdef MEM_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 16'h0000;
        end else if (busy && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'h0001;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus randomized op streams
// checked against a transaction-level expectation of retire values and stall lengths.
module tb_mem_access_stage;

    localparam int unsigned MAXW = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_memread, ex_memwrite;
    logic [15:0] ex_addr, ex_wdata, ex_aluval;
    logic [3:0]  ex_dstreg;
    logic        ex_regwrite, ex_memtoreg, ex_halt;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ready;
    logic [15:0] MEM_ALUval, MEM_ReadData;
    logic [3:0]  MEM_DstReg;
    logic        MEM_RegWrite, MEM_MemtoReg, MEM_halt;
    logic        stall, mem_err;
`ifdef MEM_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    logic [38:0] outs;
    assign outs = {MEM_ALUval, MEM_ReadData, MEM_DstReg, MEM_RegWrite, MEM_MemtoReg, MEM_halt};

    int   n_cmp = 0;
    int   n_bad = 0;
    logic exp_err;
    int   exp_stall;

    always #5 clk = ~clk;

    mem_access_stage #(.MAX_WAIT(MAXW)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_memread   (ex_memread),
        .ex_memwrite  (ex_memwrite),
        .ex_addr      (ex_addr),
        .ex_wdata     (ex_wdata),
        .ex_aluval    (ex_aluval),
        .ex_dstreg    (ex_dstreg),
        .ex_regwrite  (ex_regwrite),
        .ex_memtoreg  (ex_memtoreg),
        .ex_halt      (ex_halt),
        .mem_en       (mem_en),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .MEM_ALUval   (MEM_ALUval),
        .MEM_ReadData (MEM_ReadData),
        .MEM_DstReg   (MEM_DstReg),
        .MEM_RegWrite (MEM_RegWrite),
        .MEM_MemtoReg (MEM_MemtoReg),
        .MEM_halt     (MEM_halt),
        .stall        (stall),
        .mem_err      (mem_err)
`ifdef MEM_STALL_CNT_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        ex_valid    = 1'b0;
        ex_memread  = 1'b0;
        ex_memwrite = 1'b0;
        ex_addr     = 16'h0;
        ex_wdata    = 16'h0;
        ex_aluval   = 16'h0;
        ex_dstreg   = 4'h0;
        ex_regwrite = 1'b0;
        ex_memtoreg = 1'b0;
        ex_halt     = 1'b0;
        mem_ready   = 1'b0;
        mem_rdata   = 16'h0;
    endtask

    task automatic set_ex(input logic v, input logic rd, input logic wr, input logic [15:0] a,
                          input logic [15:0] wd, input logic [15:0] al, input logic [3:0] d,
                          input logic rw, input logic m2r, input logic h);
        ex_valid    = v;
        ex_memread  = rd;
        ex_memwrite = wr;
        ex_addr     = a;
        ex_wdata    = wd;
        ex_aluval   = al;
        ex_dstreg   = d;
        ex_regwrite = rw;
        ex_memtoreg = m2r;
        ex_halt     = h;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (outs !== 39'h0) begin
            n_bad++;
            $display("FAIL reset_outs: got %h want 0", outs);
        end
        n_cmp++;
        if ({mem_en, mem_wr, stall, mem_err} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 0000", {mem_en, mem_wr, stall, mem_err});
        end
        n_cmp++;
        if ({mem_addr, mem_wdata} !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_bus: got %h want 0", {mem_addr, mem_wdata});
        end
`ifdef MEM_STALL_CNT_EN
        n_cmp++;
        if (stall_cnt !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
        end
`endif
        rst       = 1'b0;
        exp_err   = 1'b0;
        exp_stall = 0;
    endtask

    task automatic test_alu;
        logic [15:0] a;
        logic [3:0]  d;
        logic        rw, m2r;
        set_ex(1'b1, 1'b0, 1'b0, 16'h9999, 16'h8888, 16'h1234, 4'd5, 1'b1, 1'b0, 1'b0);
        tick();
        n_cmp++;
        if (outs !== {16'h1234, 16'h0, 4'd5, 1'b1, 1'b0, 1'b0} || stall !== 1'b0) begin
            n_bad++;
            $display("FAIL alu_basic: got %h stall %b want %h stall 0", outs, stall,
                     {16'h1234, 16'h0, 4'd5, 1'b1, 1'b0, 1'b0});
        end
        for (int i = 0; i < 8; i++) begin
            a   = 16'($urandom);
            d   = 4'($urandom_range(15));
            rw  = 1'($urandom);
            m2r = 1'($urandom);
            set_ex(1'b1, 1'b0, 1'b0, 16'($urandom), 16'($urandom), a, d, rw, m2r, 1'b0);
            mem_ready = 1'($urandom);
            tick();
            n_cmp++;
            if (outs !== {a, 16'h0, d, rw, m2r, 1'b0} || {stall, mem_en} !== 2'b00) begin
                n_bad++;
                $display("FAIL alu_b2b[%0d]: got %h stall %b want %h stall 0", i, outs, stall,
                         {a, 16'h0, d, rw, m2r, 1'b0});
            end
        end
        idle_inputs();
        tick();
        n_cmp++;
        if (outs !== 39'h0) begin
            n_bad++;
            $display("FAIL alu_idle_bubble: got %h want 0", outs);
        end
    endtask

    task automatic test_load;
        set_ex(1'b1, 1'b1, 1'b0, 16'h0040, 16'h7777, 16'h0ABC, 4'd3, 1'b1, 1'b1, 1'b0);
        tick();
        for (int k = 1; k <= 3; k++) begin
            n_cmp++;
            if ({stall, mem_en, mem_wr} !== 3'b110 || mem_addr !== 16'h0040 || outs !== 39'h0) begin
                n_bad++;
                $display("FAIL load_busy[%0d]: got st/en/wr %b addr %h outs %h want 110 0040 0",
                         k, {stall, mem_en, mem_wr}, mem_addr, outs);
            end
            mem_ready = (k == 3);
            mem_rdata = (k == 3) ? 16'hBEEF : 16'($urandom);
            tick();
        end
        exp_stall += 3;
        set_ex(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h5555, 4'd2, 1'b1, 1'b0, 1'b0);
        mem_ready = 1'b0;
        n_cmp++;
        if (outs !== {16'h0ABC, 16'hBEEF, 4'd3, 1'b1, 1'b1, 1'b0} || {stall, mem_en} !== 2'b00
            || mem_addr !== 16'h0) begin
            n_bad++;
            $display("FAIL load_retire: got %h st/en %b addr %h want %h 00 0000", outs,
                     {stall, mem_en}, mem_addr, {16'h0ABC, 16'hBEEF, 4'd3, 1'b1, 1'b1, 1'b0});
        end
        tick();
        n_cmp++;
        if (outs !== {16'h5555, 16'h0, 4'd2, 1'b1, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL load_next_alu: got %h want %h", outs,
                     {16'h5555, 16'h0, 4'd2, 1'b1, 1'b0, 1'b0});
        end
        idle_inputs();
    endtask

    task automatic test_store;
        set_ex(1'b1, 1'b0, 1'b1, 16'h0010, 16'hA5A5, 16'h0011, 4'd7, 1'b0, 1'b0, 1'b0);
        tick();
        mem_ready = 1'b1;
        n_cmp++;
        if ({stall, mem_en, mem_wr} !== 3'b111 || mem_addr !== 16'h0010 || mem_wdata !== 16'hA5A5)
        begin
            n_bad++;
            $display("FAIL store_busy: got st/en/wr %b addr %h wdata %h want 111 0010 a5a5",
                     {stall, mem_en, mem_wr}, mem_addr, mem_wdata);
        end
        tick();
        exp_stall += 1;
        idle_inputs();
        n_cmp++;
        if (outs !== {16'h0011, 16'h0, 4'd7, 1'b0, 1'b0, 1'b0} || {stall, mem_wr} !== 2'b00) begin
            n_bad++;
            $display("FAIL store_retire: got %h st/wr %b want %h 00", outs, {stall, mem_wr},
                     {16'h0011, 16'h0, 4'd7, 1'b0, 1'b0, 1'b0});
        end
    endtask

    task automatic test_timeout;
        // Ready on the last allowed BUSY cycle completes normally.
        set_ex(1'b1, 1'b1, 1'b0, 16'h0100, 16'h0, 16'h0022, 4'd9, 1'b1, 1'b1, 1'b0);
        tick();
        for (int k = 1; k <= int'(MAXW); k++) begin
            mem_ready = (k == int'(MAXW));
            mem_rdata = 16'h1357;
            tick();
        end
        exp_stall += MAXW;
        idle_inputs();
        n_cmp++;
        if (outs !== {16'h0022, 16'h1357, 4'd9, 1'b1, 1'b1, 1'b0} || {stall, mem_err} !== 2'b00)
        begin
            n_bad++;
            $display("FAIL ready_at_limit: got %h st/err %b want %h 00", outs, {stall, mem_err},
                     {16'h0022, 16'h1357, 4'd9, 1'b1, 1'b1, 1'b0});
        end
        set_ex(1'b1, 1'b1, 1'b0, 16'h0200, 16'h0, 16'h0033, 4'd4, 1'b1, 1'b1, 1'b0);
        tick();
        for (int k = 1; k <= int'(MAXW); k++) begin
            n_cmp++;
            if ({stall, mem_err} !== 2'b10) begin
                n_bad++;
                $display("FAIL timeout_wait[%0d]: got st/err %b want 10", k, {stall, mem_err});
            end
            mem_ready = 1'b0;
            tick();
        end
        exp_stall += MAXW;
        exp_err = 1'b1;
        set_ex(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h4242, 4'd6, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (outs !== 39'h0 || {stall, mem_en, mem_err} !== 3'b001) begin
            n_bad++;
            $display("FAIL timeout_retire: got %h st/en/err %b want 0 001", outs,
                     {stall, mem_en, mem_err});
        end
        tick();
        n_cmp++;
        if (outs !== {16'h4242, 16'h0, 4'd6, 1'b1, 1'b0, 1'b0} || mem_err !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_next_alu: got %h err %b want %h 1", outs, mem_err,
                     {16'h4242, 16'h0, 4'd6, 1'b1, 1'b0, 1'b0});
        end
        idle_inputs();
    endtask

    task automatic test_reset_busy;
        set_ex(1'b1, 1'b1, 1'b0, 16'h0300, 16'h0, 16'h0044, 4'd8, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        n_cmp++;
        if (stall !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_busy_pre: got stall %b want 1", stall);
        end
        idle_inputs();
        rst       = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 16'hFFFF;
        tick();
        rst       = 1'b0;
        mem_ready = 1'b0;
        exp_err   = 1'b0;
        exp_stall = 0;
        n_cmp++;
        if (outs !== 39'h0 || {mem_en, stall, mem_err} !== 3'b000) begin
            n_bad++;
            $display("FAIL rst_busy: got %h en/st/err %b want 0 000", outs,
                     {mem_en, stall, mem_err});
        end
    endtask

    task automatic test_random;
        int          kind, lat, busy_len;
        logic        v, rd, wr, rw, m2r, tmo;
        logic [15:0] a, wd, al, rdat;
        logic [3:0]  d;
        logic [38:0] exp;
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(3);
            v    = ($urandom_range(9) != 0);
            a    = 16'($urandom);
            wd   = 16'($urandom);
            al   = 16'($urandom);
            rdat = 16'($urandom);
            d    = 4'($urandom_range(15));
            rw   = 1'($urandom);
            m2r  = 1'($urandom);
            rd   = (kind == 1) || (kind == 3);
            wr   = (kind == 2) || (kind == 3);
            set_ex(v, rd, wr, a, wd, al, d, rw, m2r, 1'b0);
            if (!v || kind == 0) begin
                mem_ready = 1'($urandom);
                tick();
                exp = v ? {al, 16'h0, d, rw, m2r, 1'b0} : 39'h0;
                n_cmp++;
                if (outs !== exp || stall !== 1'b0) begin
                    n_bad++;
                    $display("FAIL rand_alu[%0d]: got %h st %b want %h 0", i, outs, stall, exp);
                end
            end else begin
                lat      = $urandom_range(17);
                tmo      = (lat >= int'(MAXW));
                busy_len = tmo ? int'(MAXW) : lat + 1;
                tick();
                for (int k = 0; k < busy_len; k++) begin
                    n_cmp++;
                    if ({stall, mem_en, mem_wr} !== {2'b11, (kind == 2)} || mem_addr !== a
                        || mem_wdata !== wd || outs !== 39'h0) begin
                        n_bad++;
                        $display("FAIL rand_busy[%0d.%0d]: st/en/wr %b addr %h wd %h outs %h",
                                 i, k, {stall, mem_en, mem_wr}, mem_addr, mem_wdata, outs);
                    end
                    mem_ready = (k == lat);
                    mem_rdata = (k == lat) ? rdat : 16'($urandom);
                    tick();
                end
                idle_inputs();
                exp_stall += busy_len;
                exp_err    = exp_err | tmo;
                exp = tmo ? 39'h0 : {al, (kind == 2) ? 16'h0 : rdat, d, rw, m2r, 1'b0};
                n_cmp++;
                if (outs !== exp || {stall, mem_err} !== {1'b0, exp_err}) begin
                    n_bad++;
                    $display("FAIL rand_retire[%0d]: got %h st/err %b want %h 0%b", i, outs,
                             {stall, mem_err}, exp, exp_err);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_halt;
        set_ex(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h00AA, 4'd1, 1'b1, 1'b0, 1'b1);
        tick();
        n_cmp++;
        if (outs !== {16'h00AA, 16'h0, 4'd1, 1'b1, 1'b0, 1'b1} || stall !== 1'b0) begin
            n_bad++;
            $display("FAIL halt_emit: got %h st %b want %h 0", outs, stall,
                     {16'h00AA, 16'h0, 4'd1, 1'b1, 1'b0, 1'b1});
        end
        for (int i = 0; i < 8; i++) begin
            set_ex(1'b1, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                   16'($urandom), 4'($urandom_range(15)), 1'b1, 1'($urandom), 1'b0);
            mem_ready = 1'($urandom);
            tick();
            n_cmp++;
            if (outs !== 39'h0 || {stall, mem_en} !== 2'b00) begin
                n_bad++;
                $display("FAIL halted[%0d]: got %h st/en %b want 0 00", i, outs, {stall, mem_en});
            end
        end
`ifdef MEM_STALL_CNT_EN
        n_cmp++;
        if (stall_cnt !== 16'(exp_stall)) begin
            n_bad++;
            $display("FAIL stall_cnt: got %0d want %0d", stall_cnt, exp_stall);
        end
`endif
        idle_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_timeout();
        test_reset_busy();
        test_random();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15: maximum BUSY cycles before a memory timeout.
REQ-002 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-003 SHALL have port clk, input, 1: rising-edge clock.
REQ-004 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-005 SHALL have port ex_valid, input, 1: EX_MEM holds a valid instruction.
REQ-006 SHALL have ports ex_memread and ex_memwrite, input, 1 each: load or store request.
REQ-007 SHALL have ports ex_addr and ex_wdata, input, 16 each: memory address and store data.
REQ-008 SHALL have port ex_aluval, input, 16: ALU result.
REQ-009 SHALL have port ex_dstreg, input, 4: destination register.
REQ-010 SHALL have ports ex_regwrite, ex_memtoreg and ex_halt, input, 1 each: control bits.
REQ-011 SHALL have ports mem_en and mem_wr, output, 1 each: memory request and write select.
REQ-012 SHALL have ports mem_addr and mem_wdata, output, 16 each: memory address and write data.
REQ-013 SHALL have port mem_rdata, input, 16: memory read data.
REQ-014 SHALL have port mem_ready, input, 1: memory completes the access in this cycle.
REQ-015 SHALL have ports MEM_ALUval and MEM_ReadData, output, 16 each: results to MEM_WB.
REQ-016 SHALL have port MEM_DstReg, output, 4: destination register to MEM_WB.
REQ-017 SHALL have ports MEM_RegWrite, MEM_MemtoReg and MEM_halt, output, 1 each: control bits to MEM_WB.
REQ-018 SHALL have port stall, output, 1: holds EX_MEM and all upstream stages.
REQ-019 SHALL have port mem_err, output, 1: sticky memory timeout flag.

Function
REQ-020 SHALL implement a state machine with states IDLE, BUSY and HALTED.
REQ-021 In IDLE, with ex_valid=1 and no memory op: at the clock edge, SHALL register all ex_* fields into the MEM_* outputs (1-cycle latency) and set MEM_ReadData=0.
REQ-022 In IDLE, with ex_valid=1 and ex_memread or ex_memwrite: SHALL latch addr, wdata, aluval, dstreg and control bits; enter BUSY; load a bubble into the outputs.
REQ-023 In BUSY: mem_en=1, mem_wr=latched memwrite, and mem_addr/mem_wdata SHALL be driven from the latched values and held stable until completion.
REQ-024 mem_en, mem_addr and mem_wdata SHALL be 0 outside BUSY.
REQ-025 stall SHALL be 1 exactly when the state is BUSY (combinational from state; not gated by mem_ready).
REQ-026 In BUSY, if mem_ready=1: at the edge, SHALL load the outputs from the latched fields, set MEM_ReadData=mem_rdata (read) or 0 (write), and return to IDLE.
REQ-027 The instruction following a memory op SHALL be accepted no earlier than the edge after the one that completed the op.
REQ-028 Bubble SHALL mean: MEM_RegWrite=0, MEM_MemtoReg=0, MEM_halt=0, and all data fields 0.
REQ-029 Outputs SHALL be a bubble on every cycle in which no instruction retires, so MEM_WB can keep wen=1.
REQ-030 If ex_memread and ex_memwrite are both 1: SHALL treat the op as a read, and mem_wr SHALL be 0.
REQ-031 Wait counter, 4-bit:
- SHALL clear on entry to BUSY and increment on each BUSY cycle with mem_ready=0.
- If it reaches MAX_WAIT with mem_ready=0: SHALL set mem_err=1, retire a bubble, and return to IDLE.
REQ-032 When mem_ready=1 arrives in the same cycle that the counter reaches MAX_WAIT: SHALL complete normally, with no error.
REQ-033 mem_ready SHALL be ignored outside BUSY.
REQ-034 A retiring instruction with ex_halt=1 SHALL emit MEM_halt=1 for one cycle, then enter HALTED.
REQ-035 In HALTED: outputs SHALL be bubbles, stall=0, ex_valid SHALL be ignored, and the block SHALL remain there until reset.

Reset
REQ-036 On rst=1 at a clock edge: state SHALL go to IDLE; all MEM_* outputs, the latches, the wait counter, mem_err and the stall counter SHALL be 0.
REQ-037 rst=1 SHALL override every other input, including mem_ready in BUSY; an in-flight access SHALL be abandoned and mem_en SHALL be 0 the next cycle.

Configuration
REQ-038 Macro MEM_STALL_CNT_EN defined: SHALL add output stall_cnt, 16 bits, that increments on each cycle with stall=1, saturates at 0xFFFF, and clears on reset.
REQ-039 MEM_STALL_CNT_EN undefined: port stall_cnt and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-040 ALU op (ex_aluval=0x1234, dstreg=5, regwrite=1) in IDLE -> next cycle MEM_ALUval=0x1234, MEM_DstReg=5, MEM_RegWrite=1, stall=0.
REQ-041 Load, addr=0x0040, mem_ready after 3 BUSY cycles, rdata=0xBEEF -> stall=1 for 3 cycles, mem_addr=0x0040 stable, MEM_ReadData=0xBEEF on the following cycle, then a bubble is not inserted twice.
REQ-042 Store, addr=0x0010, wdata=0xA5A5, zero-wait ready -> mem_wr=1 for 1 cycle, stall=1 for 1 cycle, MEM_RegWrite=0 at retire.
REQ-043 Load with mem_ready never asserted -> after 15 BUSY cycles mem_err=1, bubble retired, state IDLE; next ALU op retires normally.
REQ-044 rst=1 in the second BUSY cycle -> next cycle mem_en=0, stall=0, all outputs 0, mem_err=0.
REQ-045 Halt op followed by an ALU op with ex_valid=1 -> MEM_halt=1 for exactly 1 cycle, then bubbles indefinitely; with MEM_STALL_CNT_EN, stall_cnt equals the total stall cycles.
